lsu_dmem_master: RTL and testbench



---
 rtl/lsu_dmem_master.sv | 142 ++++++++++++++
 tb/tb_lsu_dmem_master.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_dmem_master.sv
// rtl/lsu_dmem_master.sv - load/store unit driving a word-only data memory with sub-word RMW
// Optional alignment faulting: define LSU_MISALIGN_CHECK_EN.
module lsu_dmem_master #(
  parameter int MEM_AW = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        err,
  output logic        busy,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_read,
  output logic        mem_write
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_RMW_RD = 3'd2,
    S_WR     = 3'd3,
    S_ERR    = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t      state, state_nx;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [15:0] wdata_q;
  logic        err_q;

  logic        accept;
  logic        fault;
  logic        out_of_range;
  logic        bad_funct3;
  logic        misalign;
  logic [31:0] load_val;
  logic [31:0] merged;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [4:0]  byte_sh;
  logic [4:0]  half_sh;

  assign accept       = (state == S_IDLE) && req;
  assign out_of_range = |addr[31:MEM_AW+2];
  assign bad_funct3   = we ? (funct3[2] || (funct3[1:0] == 2'b11))
                           : ((funct3 == 3'd3) || (funct3[2:1] == 2'b11));
`ifdef LSU_MISALIGN_CHECK_EN
  assign misalign = ((funct3[1:0] == 2'b01) && addr[0]) ||
                    ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif
  assign fault = out_of_range || bad_funct3 || misalign;

  // Lane selection always uses the latched address, so alignment off just picks the containing lane.
  assign byte_sh = {addr_q[1:0], 3'b000};
  assign half_sh = {addr_q[1], 4'b0000};
  assign lane_b  = mem_rdata[byte_sh +: 8];
  assign lane_h  = mem_rdata[half_sh +: 16];

  always_comb begin
    load_val = mem_rdata;
    case (funct3_q)
      3'd0:    load_val = {{24{lane_b[7]}}, lane_b};
      3'd4:    load_val = {24'h000000, lane_b};
      3'd1:    load_val = {{16{lane_h[15]}}, lane_h};
      3'd5:    load_val = {16'h0000, lane_h};
      default: load_val = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (funct3_q[1:0] == 2'b00)
      merged[byte_sh +: 8] = wdata_q[7:0];
    else
      merged[half_sh +: 16] = wdata_q;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (fault)                    state_nx = S_ERR;
          else if (!we)                 state_nx = S_RD;
          else if (funct3[1:0] == 2'b10) state_nx = S_WR;
          else                          state_nx = S_RMW_RD;
        end
      end
      S_RD:     state_nx = S_DONE;
      S_RMW_RD: state_nx = S_WR;
      S_WR:     state_nx = S_DONE;
      S_ERR:    state_nx = S_DONE;
      S_DONE:   state_nx = S_IDLE;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      funct3_q  <= 3'd0;
      addr_q    <= 32'd0;
      wdata_q   <= 16'd0;
      err_q     <= 1'b0;
      rdata     <= 32'd0;
      mem_wdata <= 32'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        funct3_q <= funct3;
        addr_q   <= addr;
        wdata_q  <= wdata[15:0];
        err_q    <= fault;
        if (!fault && we && (funct3[1:0] == 2'b10))
          mem_wdata <= wdata;
      end
      if (state == S_RD)
        rdata <= load_val;
      if (state == S_RMW_RD)
        mem_wdata <= merged;
    end
  end

  // Strobes decode from the state register alone so reset kills them without waiting for an edge.
  assign mem_read  = (state == S_RD) || (state == S_RMW_RD);
  assign mem_write = (state == S_WR);
  assign done      = (state == S_DONE);
  assign err       = (state == S_DONE) && err_q;
  assign busy      = (state != S_IDLE);
  assign mem_addr  = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_lsu_dmem_master.sv
// tb/tb_lsu_dmem_master.sv - scoreboard bench for lsu_dmem_master with a word memory model
module tb_lsu_dmem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic [2:0]  funct3 = 3'd0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done, err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  lsu_dmem_master #(.MEM_AW(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .funct3(funct3), .addr(addr),
    .wdata(wdata), .rdata(rdata), .done(done), .err(err), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .mem_read(mem_read), .mem_write(mem_write)
  );

  always #5 clk = ~clk;

  logic [31:0] dmem [0:255];
  assign mem_rdata = mem_read ? dmem[mem_addr[9:2]] : 32'h0;
  always @(posedge clk) if (mem_write) dmem[mem_addr[9:2]] <= mem_wdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          done_cyc;
    int          n_rd;
    int          n_wr;
    logic        chk_word;
    int          widx;
  } exp_t;

  exp_t        sbq[$];
  logic [31:0] ref_mem [0:255];
  logic [31:0] ref_rdata = 32'd0;
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0;
      wr_cnt = 0;
    end else begin
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (done) begin
        if (sbq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("rdata", rdata, e.rdata);
          chk("done_cycle", cyc, e.done_cyc);
          chk("read_cycles", rd_cnt, e.n_rd);
          chk("write_cycles", wr_cnt, e.n_wr);
          if (e.chk_word) chk("mem_word", dmem[e.widx], ref_mem[e.widx]);
        end
        rd_cnt = 0;
        wr_cnt = 0;
      end
    end
  end

  // Reference model: plain arithmetic on a word array, independent of the DUT's state machine.
  function automatic exp_t model(input logic w_en, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] wd);
    exp_t        e;
    int          idx;
    int          bsh, hsh;
    logic [31:0] w, b, h;
    logic        flt;
    idx = int'(a[9:2]);
    w   = ref_mem[idx];
    bsh = 8 * int'(a % 4);
    hsh = 16 * int'((a / 2) % 2);
    b   = (w >> bsh) & 32'hFF;
    h   = (w >> hsh) & 32'hFFFF;
    flt = (a >= 32'd1024) || (w_en && f3 > 3'd2) ||
          (!w_en && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7));
`ifdef LSU_MISALIGN_CHECK_EN
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) flt = 1'b1;
    if (f3 == 3'd2 && (a % 4 != 0)) flt = 1'b1;
`endif
    e.err = flt; e.chk_word = 1'b0; e.widx = idx; e.n_rd = 0; e.n_wr = 0;
    e.done_cyc = cyc + 2;
    if (!flt && !w_en) begin
      e.n_rd = 1;
      case (f3)
        3'd0: ref_rdata = (b >= 128) ? (b + 32'hFFFFFF00) : b;
        3'd4: ref_rdata = b;
        3'd1: ref_rdata = (h >= 32768) ? (h + 32'hFFFF0000) : h;
        3'd5: ref_rdata = h;
        default: ref_rdata = w;
      endcase
    end else if (!flt) begin
      e.n_wr = 1;
      e.chk_word = 1'b1;
      if (f3 == 3'd2) begin
        ref_mem[idx] = wd;
      end else if (f3 == 3'd0) begin
        ref_mem[idx] = (w & ~(32'hFF << bsh)) | ((wd & 32'hFF) << bsh);
        e.n_rd = 1; e.done_cyc = cyc + 3;
      end else begin
        ref_mem[idx] = (w & ~(32'hFFFF << hsh)) | ((wd & 32'hFFFF) << hsh);
        e.n_rd = 1; e.done_cyc = cyc + 3;
      end
    end
    e.rdata = ref_rdata;
    return e;
  endfunction

  task automatic issue(input logic w_en, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic poke);
    @(negedge clk);
    sbq.push_back(model(w_en, f3, a, wd));
    req = 1'b1; we = w_en; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
    req = 1'b0;
    if (poke) begin
      req = 1'b1; we = 1'b0; funct3 = 3'd2; addr = 32'h0;
      @(negedge clk);
      req = 1'b0;
    end
    for (int i = 0; i < 12 && sbq.size() != 0; i++) @(negedge clk);
    if (sbq.size() != 0) begin
      chk("done_timeout", 32'd0, 32'd1);
      sbq.delete();
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      dmem[i] = $urandom;
      ref_mem[i] = dmem[i];
    end
    repeat (3) @(negedge clk);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    rst_n = 1'b1;

    issue(1'b1, 3'd2, 32'h100, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 3'd2, 32'h100, 32'h0, 1'b0);
    chk("lw_100", rdata, 32'hDEADBEEF);
    issue(1'b1, 3'd2, 32'h104, 32'h11223344, 1'b0);
    issue(1'b1, 3'd0, 32'h105, 32'h000000AA, 1'b0);
    issue(1'b0, 3'd2, 32'h104, 32'h0, 1'b0);
    chk("sb_word", rdata, 32'h1122AA44);
    issue(1'b0, 3'd0, 32'h105, 32'h0, 1'b0);
    chk("lb_105", rdata, 32'hFFFFFFAA);
    issue(1'b0, 3'd4, 32'h105, 32'h0, 1'b0);
    chk("lbu_105", rdata, 32'h000000AA);
    issue(1'b1, 3'd1, 32'h106, 32'h00008001, 1'b0);
    issue(1'b0, 3'd2, 32'h104, 32'h0, 1'b0);
    chk("sh_word", rdata, 32'h8001AA44);
    issue(1'b0, 3'd1, 32'h106, 32'h0, 1'b0);
    chk("lh_106", rdata, 32'hFFFF8001);
    issue(1'b0, 3'd5, 32'h106, 32'h0, 1'b0);
    chk("lhu_106", rdata, 32'h00008001);
    issue(1'b0, 3'd2, 32'h102, 32'h0, 1'b0);
    issue(1'b0, 3'd2, 32'h400, 32'h0, 1'b0);
    issue(1'b1, 3'd0, 32'h10B, 32'h5A5A5A77, 1'b1);

    // Reset while an SB sits in its write cycle: the write must not land.
    @(negedge clk);
    req = 1'b1; we = 1'b1; funct3 = 3'd0; addr = 32'h10C; wdata = 32'h000000EE;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 6 && !mem_write; i++) @(negedge clk);
    chk("reached_wr", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_wr_drop", {31'd0, mem_write}, 32'd0);
    @(negedge clk);
    chk("rst_word_kept", dmem[67], ref_mem[67]);
    chk("rst_outs", {28'd0, done, err, busy, mem_read}, 32'd0);
    chk("rst_rdata_mid", rdata, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    ref_rdata = 32'd0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      logic [31:0] a;
      int r;
      r = int'($urandom % 16);
      if (r == 0) a = $urandom;
      else if (r == 1) a = 32'h400 + ($urandom % 16);
      else a = $urandom % 1024;
      issue(1'($urandom % 2), 3'($urandom % 8), a, $urandom, 1'($urandom % 8 == 0));
    end

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
